// File: rtl/imu_stim_gen.sv
// Synthetic multi-channel IMU stimulus generator.
// A start pulse latches a run configuration. The block then streams a bounded
// sequence of NUM_CH-wide samples over a valid/ready interface. The waveform
// can be a ramp, a constant, a triangle or LFSR noise. The run can loop
// continuously or be aborted with stop.
module imu_stim_gen #(
  parameter int          DATA_WIDTH = 16,
  parameter int          NUM_CH     = 3,
  parameter int          SEQ_LEN    = 16,
  parameter int          CH_OFFSET  = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         LEN_W      = $clog2(SEQ_LEN + 1),
  localparam int         IDX_W      = $clog2(SEQ_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [1:0]                   mode,
  input  logic [DATA_WIDTH-1:0]        base,
  input  logic [DATA_WIDTH-1:0]        step,
  input  logic [LEN_W-1:0]             len,
  input  logic                         loop_en,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [IDX_W-1:0]             sample_idx,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  typedef enum logic [1:0] {MODE_RAMP, MODE_CONST, MODE_TRI, MODE_LFSR} mode_e;

  state_e                        state_q, state_d;
  mode_e                         mode_q, mode_d;
  logic [DATA_WIDTH-1:0]         base_q, base_d;
  logic [DATA_WIDTH-1:0]         step_q, step_d;
  logic [LEN_W-1:0]              len_q, len_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [15:0]                   lfsr_q, lfsr_d;
  logic [NUM_CH*DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          handshake;
  logic                          at_last;
  logic [LEN_W-1:0]              len_clamped;
  logic [15:0]                   lfsr_step;

  // A length of 0, or one above SEQ_LEN, means a full SEQ_LEN pass.
  assign len_clamped = (len == '0 || len > LEN_W'(SEQ_LEN)) ? LEN_W'(SEQ_LEN) : len;
  assign handshake   = out_valid_q & out_ready;
  assign at_last     = (LEN_W'(idx_q) == len_q - LEN_W'(1));
  // Galois right-shift LFSR with taps 0xB400.
  assign lfsr_step   = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Run control: config latch, index/LFSR advance, pass wrap, stop and completion.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    step_d      = step_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          mode_d      = mode_e'(mode);
          base_d      = base;
          step_d      = step;
          len_d       = len_clamped;
          idx_d       = '0;
          lfsr_d      = LFSR_SEED;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ST_RUN: begin
        // stop wins over the advance. A handshake in this cycle still counts as
        // transferred, because nothing follows it.
        if (stop) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (handshake) begin
          lfsr_d = lfsr_step;
          if (at_last) begin
            if (loop_en) begin
              idx_d = '0;
            end else begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [LEN_W-1:0]             half_len;
  logic [IDX_W-1:0]             tri_idx;
  logic [DATA_WIDTH-1:0]        ramp_term;
  logic [DATA_WIDTH-1:0]        tri_term;
  logic [DATA_WIDTH-1:0]        lfsr_term;
  logic [NUM_CH*DATA_WIDTH-1:0] sample_d;

  // Sample that will be presented next, computed from the next-state index,
  // LFSR and configuration. All arithmetic wraps modulo 2^DATA_WIDTH.
  always_comb begin
    half_len  = len_d >> 1;
    tri_idx   = (LEN_W'(idx_d) < half_len) ? idx_d
                                           : IDX_W'(len_d - LEN_W'(1) - LEN_W'(idx_d));
    ramp_term = DATA_WIDTH'(idx_d) * step_d;
    tri_term  = DATA_WIDTH'(tri_idx) * step_d;
    lfsr_term = DATA_WIDTH'(lfsr_d);
    sample_d  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode_d)
        MODE_RAMP:  sample_d[c*DATA_WIDTH +: DATA_WIDTH] = base_d + ramp_term + DATA_WIDTH'(c * CH_OFFSET);
        MODE_CONST: sample_d[c*DATA_WIDTH +: DATA_WIDTH] = base_d + DATA_WIDTH'(c * CH_OFFSET);
        MODE_TRI:   sample_d[c*DATA_WIDTH +: DATA_WIDTH] = base_d + tri_term + DATA_WIDTH'(c * CH_OFFSET);
        default:    sample_d[c*DATA_WIDTH +: DATA_WIDTH] = lfsr_term ^ DATA_WIDTH'(c * CH_OFFSET);
      endcase
    end
  end

  // Output registers. Data is reloaded only while a sample is being
  // presented, so it holds steady under backpressure and after a run ends.
  always_comb begin
    out_data_d = out_valid_d ? sample_d : out_data_q;
    out_last_d = out_valid_d & (LEN_W'(idx_d) == len_d - LEN_W'(1));
  end

  // State and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      // NOTE: there is no memory array here, so every flop can take a reset value.
      state_q     <= ST_IDLE;
      mode_q      <= MODE_RAMP;
      base_q      <= '0;
      step_q      <= '0;
      len_q       <= LEN_W'(SEQ_LEN);
      idx_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      step_q      <= step_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign sample_idx = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
